// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a small transmit FIFO.
// Frames are start, LSB-first data, optional parity, then one or two stop bits.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          TX_Send,
  input  logic [DATA_BITS-1:0]          Input_Byte,
  output logic                          TX_Ready,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_Count,
  output logic                          Main_TX_Active,
  output logic                          Output_Serial,
  output logic                          TX_Done
);

  localparam int PW         = $clog2(FIFO_DEPTH);
  localparam int CW         = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CLK_LAST_I = CLKS_PER_BIT - 1;
  localparam int DATA_LAST_I = DATA_BITS - 1;
  localparam int STOP_LAST_I = STOP_BITS - 1;

  localparam logic [CW-1:0] CLK_LAST  = CLK_LAST_I[CW-1:0];
  localparam logic [3:0]    DATA_LAST = DATA_LAST_I[3:0];
  localparam logic [3:0]    STOP_LAST = STOP_LAST_I[3:0];
  localparam logic [PW:0]   DEPTH     = FIFO_DEPTH[PW:0];

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  parity_q, parity_d;

  logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PW:0]           count_q;
  logic [DATA_BITS-1:0]  head;

  logic push, pop, bit_end, frame_end;

  assign head      = mem_q[rd_ptr_q];
  assign TX_Ready  = (count_q < DEPTH);
  assign push      = TX_Send && TX_Ready;
  assign bit_end   = (clk_cnt_q == CLK_LAST);
  assign frame_end = (state_q == ST_STOP) && bit_end && (bit_cnt_q == STOP_LAST);
  // Only words already counted before this edge may pop, so a push never falls through.
  assign pop       = (count_q != '0) && ((state_q == ST_IDLE) || frame_end);

  always_ff @(posedge Clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= Input_Byte;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    parity_d  = parity_q;

    if (state_q != ST_IDLE) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + CW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        // The data register shifts so the current bit is always at position 0.
        if (bit_end) begin
          data_d = data_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d   = ST_STOP;
          bit_cnt_d = '0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase

    if (pop) begin
      state_d   = ST_START;
      clk_cnt_d = '0;
      bit_cnt_d = '0;
      data_d    = head;
      parity_d  = (PARITY == 1) ? ~(^head) : (^head);
    end
  end

  always_comb begin
    Output_Serial = 1'b1;
    case (state_q)
      ST_START:  Output_Serial = 1'b0;
      ST_DATA:   Output_Serial = data_q[0];
      ST_PARITY: Output_Serial = parity_q;
      default:   Output_Serial = 1'b1;
    endcase
  end

  assign Main_TX_Active = (state_q != ST_IDLE);
  assign TX_Done        = frame_end;
  assign FIFO_Count     = count_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: four parameterisations share one clock,
// a selector routes the instance under test to a bit-level frame receiver.
module tb_uart_tx_param;

  localparam int C = 217;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_send;
  logic [7:0] din;
  logic [1:0] sel;
  logic [3:0] send_v;

  logic [3:0] ser_w, act_w, done_w, ready_w;
  logic [2:0] cnt_w [4];
  logic       ser, act, done, ready;
  logic [2:0] cnt;

  logic [7:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;

  logic [7:0] rx_word;
  logic       rx_start, rx_pbit, rx_stop_ok;
  int         rx_glitch, rx_inact, rx_xdone, rx_done_at, rx_len;

  always #5 clk = ~clk;

  always_comb send_v = tx_send ? (4'b0001 << sel) : 4'b0000;

  always_comb begin
    ser   = ser_w[sel];
    act   = act_w[sel];
    done  = done_w[sel];
    ready = ready_w[sel];
    cnt   = cnt_w[sel];
  end

  always @(posedge clk) if (done === 1'b1) done_seen <= done_seen + 1;

  uart_tx_param u_def (
    .Clock(clk), .Reset(rst), .TX_Send(send_v[0]), .Input_Byte(din),
    .TX_Ready(ready_w[0]), .FIFO_Count(cnt_w[0]), .Main_TX_Active(act_w[0]),
    .Output_Serial(ser_w[0]), .TX_Done(done_w[0]));

  uart_tx_param #(.PARITY(2)) u_even (
    .Clock(clk), .Reset(rst), .TX_Send(send_v[1]), .Input_Byte(din),
    .TX_Ready(ready_w[1]), .FIFO_Count(cnt_w[1]), .Main_TX_Active(act_w[1]),
    .Output_Serial(ser_w[1]), .TX_Done(done_w[1]));

  uart_tx_param #(.PARITY(1)) u_odd (
    .Clock(clk), .Reset(rst), .TX_Send(send_v[2]), .Input_Byte(din),
    .TX_Ready(ready_w[2]), .FIFO_Count(cnt_w[2]), .Main_TX_Active(act_w[2]),
    .Output_Serial(ser_w[2]), .TX_Done(done_w[2]));

  uart_tx_param #(.DATA_BITS(7), .STOP_BITS(2)) u_d7s2 (
    .Clock(clk), .Reset(rst), .TX_Send(send_v[3]), .Input_Byte(din[6:0]),
    .TX_Ready(ready_w[3]), .FIFO_Count(cnt_w[3]), .Main_TX_Active(act_w[3]),
    .Output_Serial(ser_w[3]), .TX_Done(done_w[3]));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_act(input string tag, input int limit, output int waited);
    int n = 0;
    while (act !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    check_val(tag, 32'(act), 32'd1);
    waited = n;
  endtask

  // Called on the first cycle of a frame; returns on the cycle after its last.
  task automatic rx_frame(input int nb, input int pe, input int ns);
    int total;
    logic [31:0] sh;
    logic cur;
    total = 1 + nb + pe + ns;
    sh = '0;
    rx_glitch = 0; rx_inact = 0; rx_xdone = 0; rx_done_at = -1;
    for (int b = 0; b < total; b++) begin
      cur = ser;
      sh = sh | (32'(cur) << b);
      for (int k = 0; k < C; k++) begin
        if (ser !== cur) rx_glitch++;
        if (act !== 1'b1) rx_inact++;
        if (done === 1'b1) begin
          if (rx_done_at < 0) rx_done_at = b * C + k;
          else rx_xdone++;
        end
        step();
      end
    end
    rx_start   = sh[0];
    rx_word    = 8'((sh >> 1) & ((32'd1 << nb) - 32'd1));
    rx_pbit    = (pe != 0) ? 1'((sh >> (1 + nb)) & 32'd1) : 1'b0;
    rx_stop_ok = (((sh >> (1 + nb + pe)) & ((32'd1 << ns) - 32'd1)) == ((32'd1 << ns) - 32'd1));
    rx_len     = total * C;
    $display("rx inst=%0d word=%02h parity=%0d done_at=%0d", sel, rx_word, rx_pbit, rx_done_at);
  endtask

  task automatic check_rx(input string tag);
    logic [7:0] e;
    check_val({tag, "_start"},   32'(rx_start), 32'd0);
    check_val({tag, "_stop"},    32'(rx_stop_ok), 32'd1);
    check_val({tag, "_glitch"},  rx_glitch, 32'd0);
    check_val({tag, "_inact"},   rx_inact, 32'd0);
    check_val({tag, "_xdone"},   rx_xdone, 32'd0);
    check_val({tag, "_done_at"}, rx_done_at, rx_len - 1);
    check_val({tag, "_sb_has"},  32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val({tag, "_word"}, 32'(rx_word), 32'(e));
    end
  endtask

  task automatic push_one(input logic [7:0] d);
    din = d;
    tx_send = 1'b1;
    exp_q.push_back(d);
    step();
    tx_send = 1'b0;
  endtask

  initial begin
    #700000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, done_base;
    rst = 1'b1; tx_send = 1'b1; din = 8'hFF; sel = 2'd0;

    // Reset state with TX_Send held high: nothing may be accepted.
    repeat (3) step();
    check_val("rst_ser",   32'(ser), 32'd1);
    check_val("rst_act",   32'(act), 32'd0);
    check_val("rst_done",  32'(done), 32'd0);
    check_val("rst_cnt",   32'(cnt), 32'd0);
    check_val("rst_ready", 32'(ready), 32'd1);

    // Single 0xFF frame; push on first edge after release, pop one edge later.
    rst = 1'b0;
    exp_q.push_back(8'hFF);
    step();
    tx_send = 1'b0;
    check_val("ff_cnt_e1", 32'(cnt), 32'd1);
    check_val("ff_act_e1", 32'(act), 32'd0);
    step();
    check_val("ff_act_e2", 32'(act), 32'd1);
    check_val("ff_ser_e2", 32'(ser), 32'd0);
    check_val("ff_cnt_e2", 32'(cnt), 32'd0);
    rx_frame(8, 0, 1);
    check_rx("ff");
    check_val("ff_len", rx_done_at + 1, 32'd2170);
    check_val("ff_idle_act", 32'(act), 32'd0);
    check_val("ff_idle_ser", 32'(ser), 32'd1);

    // Six pushes on consecutive edges against a depth-4 buffer.
    fork
      begin
        int mcnt = 0;
        bit idle = 1'b1;
        bit acc, pp;
        for (int e = 1; e <= 6; e++) begin
          din = 8'hA0 + 8'(e);
          tx_send = 1'b1;
          acc = (mcnt < 4);
          pp  = idle && (mcnt > 0);
          if (acc) exp_q.push_back(din);
          step();
          mcnt = mcnt + int'(acc) - int'(pp);
          if (pp) idle = 1'b0;
          check_val($sformatf("fill_cnt_e%0d", e),   32'(cnt), mcnt);
          check_val($sformatf("fill_ready_e%0d", e), 32'(ready), 32'(mcnt < 4));
          check_val($sformatf("fill_act_e%0d", e),   32'(act), 32'(!idle));
        end
        tx_send = 1'b0;
      end
      begin
        wait_act("fill_start", 20, w);
        for (int f = 0; f < 5; f++) begin
          rx_frame(8, 0, 1);
          check_rx($sformatf("fill_f%0d", f));
        end
        check_val("fill_end_act", 32'(act), 32'd0);
        check_val("fill_sb_left", exp_q.size(), 32'd0);
      end
    join

    // Push coinciding with the end-of-frame pop while two words wait.
    fork
      begin
        int n = 0;
        push_one(8'h11);
        push_one(8'h22);
        push_one(8'h33);
        while (done !== 1'b1 && n < 3000) begin
          step();
          n++;
        end
        check_val("eof_seen", 32'(done), 32'd1);
        check_val("eof_cnt_pre", 32'(cnt), 32'd2);
        push_one(8'h44);
        check_val("eof_cnt_post", 32'(cnt), 32'd2);
        check_val("eof_act_post", 32'(act), 32'd1);
      end
      begin
        wait_act("eof_start", 20, w);
        for (int f = 0; f < 4; f++) begin
          rx_frame(8, 0, 1);
          check_rx($sformatf("eof_f%0d", f));
        end
        check_val("eof_end_act", 32'(act), 32'd0);
      end
    join

    // Reset in the middle of data bit 3 with another word still buffered.
    push_one(8'h00);
    push_one(8'h3C);
    check_val("mid_act", 32'(act), 32'd1);
    repeat (4 * C + 100 - 1) step();
    check_val("mid_ser_bit3", 32'(ser), 32'd0);
    check_val("mid_cnt", 32'(cnt), 32'd1);
    done_base = done_seen;
    #2;
    rst = 1'b1;
    #1;
    check_val("mid_rst_ser",   32'(ser), 32'd1);
    check_val("mid_rst_cnt",   32'(cnt), 32'd0);
    check_val("mid_rst_act",   32'(act), 32'd0);
    check_val("mid_rst_ready", 32'(ready), 32'd1);
    exp_q.delete();
    repeat (3) step();
    rst = 1'b0;
    step();
    check_val("mid_no_done", done_seen, done_base);
    push_one(8'h5A);
    wait_act("mid_restart", 20, w);
    rx_frame(8, 0, 1);
    check_rx("mid_after");

    // Even parity, odd parity, then 7 data bits with 2 stop bits.
    sel = 2'd1;
    push_one(8'hAA);
    wait_act("even_start", 20, w);
    rx_frame(8, 1, 1);
    check_rx("even");
    check_val("even_pbit", 32'(rx_pbit), 32'd0);
    check_val("even_len", rx_done_at + 1, 32'd2387);

    sel = 2'd2;
    push_one(8'hAA);
    wait_act("odd_start", 20, w);
    rx_frame(8, 1, 1);
    check_rx("odd");
    check_val("odd_pbit", 32'(rx_pbit), 32'd1);
    check_val("odd_len", rx_done_at + 1, 32'd2387);

    sel = 2'd3;
    push_one(8'h55);
    wait_act("d7_start", 20, w);
    rx_frame(7, 0, 2);
    check_rx("d7s2");
    check_val("d7s2_len", rx_done_at + 1, 32'd2170);
    check_val("d7s2_idle", 32'(act), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217: clocks per serial bit (25 MHz / 115200); legal values >= 2.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 SHALL have parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: transmit buffer entries; legal values are powers of 2 >= 2.
REQ-006 SHALL have port Clock  input  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port TX_Send  input  1  push request, sampled on the Clock rising edge.
REQ-009 SHALL have port Input_Byte  input  DATA_BITS  data word pushed when TX_Send is accepted.
REQ-010 SHALL have port TX_Ready  output  1  high when FIFO_Count < FIFO_DEPTH.
REQ-011 SHALL have port FIFO_Count  output  $clog2(FIFO_DEPTH)+1  number of buffered, not-yet-started words.
REQ-012 SHALL have port Main_TX_Active  output  1  high from the first START cycle through the last STOP cycle.
REQ-013 SHALL have port Output_Serial  output  1  serial line; idle level 1.
REQ-014 SHALL have port TX_Done  output  1  one-cycle pulse at the end of each frame.

Function
REQ-015 SHALL accept a push on a rising edge where TX_Send=1 and TX_Ready=1, writing Input_Byte to the FIFO tail.
REQ-016 SHALL drop a push while full: no FIFO, count or output change, and no error flag.
REQ-017 SHALL leave FIFO_Count unchanged on a simultaneous accepted push and pop; SHALL increment it on a push only and decrement it on a pop only.
REQ-018 SHALL implement states IDLE, START, DATA, PARITY and STOP.
REQ-019 SHALL, in IDLE, pop the FIFO head on the rising edge when FIFO_Count > 0 and enter START.
  - No same-edge fall-through: a push at edge N into an empty FIFO pops at edge N+1.
REQ-020 SHALL hold each bit on Output_Serial for exactly CLKS_PER_BIT cycles, timed by a per-bit counter running 0..CLKS_PER_BIT-1.
REQ-021 SHALL drive the following in each state:
  - START: 0.
  - DATA: DATA_BITS bits, LSB first.
  - PARITY: present only when PARITY != 0; even = XOR of the data bits, odd = its inverse.
  - STOP: 1 for STOP_BITS bit periods.
REQ-022 SHALL give a frame length of (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
REQ-023 SHALL, on the final cycle of STOP, pulse TX_Done high for one cycle.
  - If FIFO_Count > 0 at that edge: pop and enter START directly, with no idle cycle between frames.
  - Otherwise: enter IDLE.
REQ-024 SHALL hold Main_TX_Active=1 continuously across back-to-back frames and 0 in IDLE.
REQ-025 SHALL hold Output_Serial=1 in IDLE.
REQ-026 SHALL transmit the word latched at pop; later pushes SHALL NOT alter an in-flight frame.
REQ-027 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.

Reset
REQ-028 SHALL, while Reset=1, immediately force:
  - Output_Serial=1, Main_TX_Active=0, TX_Done=0;
  - FIFO_Count=0, TX_Ready=1;
  - state IDLE, bit and clock counters 0, FIFO pointers 0.
REQ-029 SHALL, on Reset asserted mid-frame, abort the frame, discard all buffered words and emit no TX_Done.
REQ-030 SHALL ignore TX_Send while Reset=1; the first push is accepted on the first rising edge after Reset deasserts.

Verification
REQ-031 SHALL pass, with defaults, push 0xFF -> line low 217 cycles then high 1953 cycles; TX_Done after 2170 cycles; bench RX receives 0xFF.
REQ-032 SHALL pass, with PARITY=2, push 0xAA -> data bits 0,1,0,1,0,1,0,1, then parity bit 0.
  - With PARITY=1 the same push SHALL give parity bit 1.
  - Frame length SHALL be 2387 cycles in both cases.
REQ-033 SHALL pass, with FIFO_DEPTH=4, pushes on 6 consecutive edges starting from empty:
  - First word pops at edge 2.
  - FIFO_Count reaches 4 after edge 5, TX_Ready=0, and the 6th push is dropped.
  - Five frames follow with no idle gap and 5 TX_Done pulses.
REQ-034 SHALL pass, with DATA_BITS=7 and STOP_BITS=2, push 0x55 -> bits 0, 1,0,1,0,1,0,1, then 1,1; stop high 434 cycles; frame 2170 cycles.
REQ-035 SHALL pass Reset asserted during data bit 3 -> Output_Serial=1 and FIFO_Count=0 within the same cycle, no TX_Done, and a new push after release transmits correctly.
REQ-036 SHALL pass simultaneous push and end-of-frame pop with FIFO_Count=2 -> FIFO_Count stays 2, and the next frame carries the older word.
